serial_lsb_comp: RTL and testbench

Bit-serial unsigned magnitude comparator that walks two WIDTH-bit operands from the least-significant bit upward. It holds the gt/eq/lt relation in registers, and each more-significant bit overrides the relation accumulated from the lower bits. This is the sequential, LSB-first counterpart of the MSB-first combinational cascade built from one-bit compare cells. It serves the cruise-control datapath wherever speed and setpoint comparisons can be traded for area over several clocks.

---
 rtl/serial_lsb_comp.sv | 117 +++++++++++
 tb/tb_serial_lsb_comp.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_lsb_comp.sv
// serial_lsb_comp: bit-serial unsigned magnitude comparator, LSB first.
// Operands are captured on start, then one bit pair is examined per clock.
// A differing bit pair overwrites the accumulated relation, so the last
// (most significant) differing bit decides the final gt/eq/lt result.
module serial_lsb_comp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]   cnt;
    logic            rg;
    logic            re;
    logic            rl;
    logic            ng;
    logic            ne;
    logic            nl;

    // Relation after folding in the current bit pair; equal bits keep it.
    always_comb begin
        ng = rg;
        ne = re;
        nl = rl;
        if (sa[0] && !sb[0]) begin
            ng = 1'b1;
            ne = 1'b0;
            nl = 1'b0;
        end else if (!sa[0] && sb[0]) begin
            ng = 1'b0;
            ne = 1'b0;
            nl = 1'b1;
        end
    end

    // Control FSM with registered busy/done and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            rg    <= 1'b0;
            re    <= 1'b0;
            rl    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a_in;
                        sb    <= b_in;
                        cnt   <= '0;
                        rg    <= 1'b0;
                        re    <= 1'b1;
                        rl    <= 1'b0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    rg  <= ng;
                    re  <= ne;
                    rl  <= nl;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + CW'(1);
                    // Final bit: publish the relation including this bit.
                    if (cnt == LAST) begin
                        gt    <= ng;
                        eq    <= ne;
                        lt    <= nl;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Start is ignored here; always return to IDLE.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_lsb_comp.sv
// Directed self-checking bench for serial_lsb_comp (WIDTH=8 and WIDTH=1).
module tb_serial_lsb_comp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       busy, done, gt, eq, lt;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1, done1, gt1, eq1, lt1;

    int errors = 0;
    int checks = 0;

    serial_lsb_comp #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    serial_lsb_comp #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
        .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 comparison; glitch>=0 pulses an ignored start with new operands.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input int glitch,
                        input logic [2:0] exp, input string tag);
        int lat;
        int bcnt;
        logic [2:0] prev;
        logic stable;
        prev = {gt, eq, lt};
        stable = 1'b1;
        a_in = a; b_in = b; start = 1'b1;
        tick();
        start = 1'b0;
        a_in = ~a; b_in = ~b;
        lat = 0;
        bcnt = busy ? 1 : 0;
        if ({gt, eq, lt} !== prev) stable = 1'b0;
        while (!done && lat < 20) begin
            if (lat == glitch) begin
                start = 1'b1; a_in = 8'h00; b_in = 8'hFF;
            end
            tick();
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
            if (!done && {gt, eq, lt} !== prev) stable = 1'b0;
        end
        check({tag, "_lat"}, lat, 8);
        check({tag, "_busycnt"}, bcnt, 9);
        check({tag, "_rel"}, {gt, eq, lt}, exp);
        check({tag, "_hold"}, stable, 1);
        tick();
        check({tag, "_idle"}, {busy, done}, 2'b00);
    endtask

    task automatic run1(input logic a, input logic b, input logic [2:0] exp, input string tag);
        a1 = a; b1 = b; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check({tag, "_busy"}, {busy1, done1}, 2'b10);
        tick();
        check({tag, "_done"}, {done1, gt1, eq1, lt1}, {1'b1, exp});
        tick();
        check({tag, "_idle"}, {busy1, done1}, 2'b00);
    endtask

    initial begin
        int n;
        int dcnt;
        // Reset state: all outputs zero, "no result yet".
        tick(); tick();
        check("rst_outs", {busy, done, gt, eq, lt}, 5'b0);
        check("rst_outs1", {busy1, done1, gt1, eq1, lt1}, 5'b0);
        rst = 1'b0;
        tick();
        check("idle_outs", {busy, done, gt, eq, lt}, 5'b0);

        run8(8'h5A, 8'h5A, -1, 3'b010, "eq5a");
        run8(8'h80, 8'h7F, -1, 3'b100, "msb_gt");
        run8(8'h7F, 8'h80, -1, 3'b001, "msb_lt");
        run8(8'h01, 8'h02, -1, 3'b001, "mid_lt");
        run8(8'hF3, 8'hF1, -1, 3'b100, "mid_gt");
        repeat (5) tick();
        check("hold_idle", {gt, eq, lt}, 3'b100);
        run8(8'h10, 8'h20, -1, 3'b001, "next_lt");

        // Ignored start mid-SHIFT, then no second done.
        run8(8'h0F, 8'h0E, 3, 3'b100, "ign");
        dcnt = 0;
        repeat (12) begin
            tick();
            if (done || busy) dcnt++;
        end
        check("ign_nodone", dcnt, 0);

        // Async reset during SHIFT.
        a_in = 8'h12; b_in = 8'h34; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst", {busy, done, gt, eq, lt}, 5'b0);
        tick();
        #2 rst = 1'b0;
        dcnt = 0;
        repeat (12) begin
            tick();
            if (done || busy) dcnt++;
        end
        check("rst_discard", dcnt, 0);
        run8(8'h33, 8'h33, -1, 3'b010, "post_rst");

        // Back-to-back: start raised while done is high, held one more cycle.
        a_in = 8'h44; b_in = 8'h40; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        check("b2b_first", {done, gt, eq, lt}, 4'b1100);
        a_in = 8'h40; b_in = 8'h44; start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        check("b2b_second", {done, gt, eq, lt}, 4'b1001);
        dcnt = 0;
        repeat (12) begin
            tick();
            if (done) dcnt++;
        end
        check("b2b_single", dcnt, 0);

        // WIDTH=1 instance.
        run1(1'b1, 1'b0, 3'b100, "w1_gt");
        run1(1'b0, 1'b1, 3'b001, "w1_lt");
        run1(1'b1, 1'b1, 3'b010, "w1_eq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
